fwd_sel_gen: RTL and testbench
==============================

// Module: fwd_sel_gen
// PURPOSE
//  Operand-forwarding controller for the 5-stage PPC integer pipeline. Tracks destination tags of in-flight
//  instructions in EX/MEM/WB and drives the 2-bit select of the per-operand mux4 that feeds EX.
//  Raises hazard_stall for load-use dependencies. Sits in ID, directly upstream of the operand muxes.
// PARAMETERS
//  REG_AW   5   GPR index width (32 GPRs)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       synchronous, active-high reset
//  id_valid      in   1       ID holds a valid instruction
//  id_rs_a       in   REG_AW  source register A index
//  id_rs_a_used  in   1       instruction reads rs_a
//  id_rs_b       in   REG_AW  source register B index
//  id_rs_b_used  in   1       instruction reads rs_b
//  id_wr         in   1       instruction writes a GPR
//  id_rd         in   REG_AW  destination GPR index
//  id_is_load    in   1       instruction is a load (result valid at end of MEM)
//  stall_ext     in   1       downstream stall: freeze all tag stages
//  flush         in   1       kill instruction in ID (branch redirect)
//  fwd_sel_a     out  2       mux select, operand A: 0=RF 1=EX 2=MEM 3=WB
//  fwd_sel_b     out  2       mux select, operand B (same encoding)
//  hazard_stall  out  1       load-use stall request to ID/IF
// BEHAVIOUR
//  - State: three tag stages EX, MEM, WB, each {vld, rd, is_load}. rst=1 clears all vld (rd/is_load 0)
//    -> fwd_sel_a/b=0, hazard_stall=0 on the cycle after reset edge and while rst held.
//  - Outputs are combinational from stage state and ID inputs (0-cycle latency, same cycle as ID).
//  - Match(S,x) = S.vld & S.rd==x & id_x_used & id_valid. Priority youngest first: EX > MEM > WB > RF.
//  - EX match on a load -> hazard_stall=1; sel for that operand still reports 1 (ignored by stalled ID).
//  - hazard_stall = id_valid & ~flush & (EX match on either used operand with EX.is_load).
//  - Advance when stall_ext=0: WB<=MEM, MEM<=EX, EX<=insert, where insert = {id_valid&id_wr&~flush&
//    ~hazard_stall, id_rd, id_is_load}; i.e. a bubble is inserted on stall/flush/non-writer.
//  - stall_ext=1: all three stages hold (incl. vld); flush in the same cycle still forces outputs as
//    computed but has no state effect until stall_ext drops (ID re-presents or is squashed upstream).
//  - flush only squashes ID insertion; EX/MEM/WB are older and continue normally.
//  - Same rd in several stages: youngest stage wins (no multi-hit error). rs_a==rs_b: both sels identical.
//  - GPR0 is an ordinary register; the decoder clears id_rs_x_used where rA=0 means literal zero.
//  - rst mid-operation: all tags invalid next cycle regardless of stall_ext/flush.
// CONFIGURATION
//  FWD_WB_BYPASS_EN defined: WB stage participates in matching; sel=3 generated.
//  Not defined: WB stage still tracked (pipeline depth unchanged) but never matched; sel never 3
//    (register file is write-through, RF read returns WB data).
// STRUCTURE
//  - Shared header fwd_def.v: FWD_SEL_RF/EX/MEM/WB encodings (2'd0..2'd3), tag field widths; also
//    included by the datapath that instantiates mux4 on the operand path.
//  - Sub-module fwd_tag_stage: one {vld,rd,is_load} register with rst/hold/load; instantiated 3x.
//  - Top holds compare/priority logic and hazard_stall.
// TESTING
//  1 Reset: rst=1 two cycles with id_valid=1 -> sel_a=sel_b=0, hazard_stall=0 throughout.
//  2 ALU chain: add r3 then add r4,r3,r3 next cycle -> sel_a=sel_b=1; one bubble later -> 2; two -> 3
//    (macro on) / 0 (macro off).
//  3 Load-use: lwz r5 then add r6,r5,r1 -> hazard_stall=1 one cycle, bubble in EX; next cycle sel_a=2,
//    sel_b=0, hazard_stall=0.
//  4 Priority: writes to r7 in WB, MEM, EX simultaneously, ID reads r7 -> sel=1; drop EX writer -> 2.
//  5 stall_ext: hold 3 cycles with r9 writer in EX -> sel stays 1, tags unchanged; release -> sel=2.
//  6 Flush: flush=1 with writer r10 in ID, next ID reads r10 -> sel=0 (no tag inserted); rst mid-stream
//    with 3 live tags -> all sels 0 next cycle.

Source files
------------

// File: rtl/fwd_sel_gen_pkg.sv
// Shared forwarding definitions: operand mux select encodings and the priority pick.
// Included by fwd_sel_gen and by the datapath that drives the operand mux4.
package fwd_sel_gen_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF  = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_EX  = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_MEM = 2'd2;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_WB  = 2'd3;

  // Youngest producer wins: EX > MEM > WB > register file.
  function automatic logic [FWD_SEL_W-1:0] fwd_pick(input logic hit_ex,
                                                    input logic hit_mem,
                                                    input logic hit_wb);
    logic [FWD_SEL_W-1:0] sel;
    sel = FWD_SEL_RF;
    if (hit_ex)       sel = FWD_SEL_EX;
    else if (hit_mem) sel = FWD_SEL_MEM;
    else if (hit_wb)  sel = FWD_SEL_WB;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One in-flight destination tag {vld, rd, is_load} with synchronous reset,
// hold (pipeline freeze) and load.
module fwd_tag_stage #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              d_vld,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_is_load,
  output logic              q_vld,
  output logic [REG_AW-1:0] q_rd,
  output logic              q_is_load
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld     <= 1'b0;
      q_rd      <= '0;
      q_is_load <= 1'b0;
    end else if (!hold) begin
      q_vld     <= d_vld;
      q_rd      <= d_rd;
      q_is_load <= d_is_load;
    end
  end

endmodule

// File: rtl/fwd_sel_gen.sv
// Operand-forwarding controller: tracks EX/MEM/WB destination tags, drives the
// per-operand mux select and the load-use stall. Macro FWD_WB_BYPASS_EN enables WB matching.
module fwd_sel_gen
  import fwd_sel_gen_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic              id_rs_a_used,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_rs_b_used,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              stall_ext,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              hazard_stall
);

  logic              ex_vld,  mem_vld,  wb_vld;
  logic [REG_AW-1:0] ex_rd,   mem_rd,   wb_rd;
  logic              ex_is_load, mem_is_load, wb_is_load;
  logic              ins_vld;

  fwd_tag_stage #(.REG_AW(REG_AW)) u_ex (
    .clk(clk), .rst(rst), .hold(stall_ext),
    .d_vld(ins_vld), .d_rd(id_rd), .d_is_load(id_is_load),
    .q_vld(ex_vld), .q_rd(ex_rd), .q_is_load(ex_is_load)
  );

  fwd_tag_stage #(.REG_AW(REG_AW)) u_mem (
    .clk(clk), .rst(rst), .hold(stall_ext),
    .d_vld(ex_vld), .d_rd(ex_rd), .d_is_load(ex_is_load),
    .q_vld(mem_vld), .q_rd(mem_rd), .q_is_load(mem_is_load)
  );

  fwd_tag_stage #(.REG_AW(REG_AW)) u_wb (
    .clk(clk), .rst(rst), .hold(stall_ext),
    .d_vld(mem_vld), .d_rd(mem_rd), .d_is_load(mem_is_load),
    .q_vld(wb_vld), .q_rd(wb_rd), .q_is_load(wb_is_load)
  );

  logic hit_ex_a, hit_mem_a, hit_wb_a;
  logic hit_ex_b, hit_mem_b, hit_wb_b;
  logic rd_a, rd_b;

  assign rd_a = id_valid & id_rs_a_used;
  assign rd_b = id_valid & id_rs_b_used;

  assign hit_ex_a  = rd_a & ex_vld  & (ex_rd  == id_rs_a);
  assign hit_mem_a = rd_a & mem_vld & (mem_rd == id_rs_a);
  assign hit_ex_b  = rd_b & ex_vld  & (ex_rd  == id_rs_b);
  assign hit_mem_b = rd_b & mem_vld & (mem_rd == id_rs_b);

`ifdef FWD_WB_BYPASS_EN
  assign hit_wb_a = rd_a & wb_vld & (wb_rd == id_rs_a);
  assign hit_wb_b = rd_b & wb_vld & (wb_rd == id_rs_b);
`else
  // Write-through register file already returns WB data, so WB never forwards.
  assign hit_wb_a = 1'b0;
  assign hit_wb_b = 1'b0;
`endif

  assign fwd_sel_a = fwd_pick(hit_ex_a, hit_mem_a, hit_wb_a);
  assign fwd_sel_b = fwd_pick(hit_ex_b, hit_mem_b, hit_wb_b);

  // Load data only exists at end of MEM, so a consumer right behind a load must wait.
  assign hazard_stall = id_valid & ~flush & ex_is_load & (hit_ex_a | hit_ex_b);

  assign ins_vld = id_valid & id_wr & ~flush & ~hazard_stall;

  // WB is the last stage; its load flag (and, without WB bypass, the whole tag) has no consumer.
  logic unused_wb;
  assign unused_wb = ^{wb_is_load, wb_vld, wb_rd};

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Self-checking bench for fwd_sel_gen: directed scenarios followed by random traffic,
// all checked against an age-ordered queue model of in-flight writers.
module tb_fwd_sel_gen;

`ifdef FWD_WB_BYPASS_EN
  localparam int MAXAGE = 3;
`else
  localparam int MAXAGE = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_a_used, id_rs_b_used, id_wr, id_is_load;
  logic [4:0] id_rs_a, id_rs_b, id_rd;
  logic       stall_ext, flush;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       hazard_stall;

  int checks = 0;
  int errors = 0;

  fwd_sel_gen #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_a_used(id_rs_a_used),
    .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_load(id_is_load),
    .stall_ext(stall_ext), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Model: queue of in-flight writers, index 0 = youngest (EX), length always 3.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } ent_t;
  ent_t mq[$];

  function automatic logic [1:0] exp_sel(input logic [4:0] x, input logic used);
    if (!(id_valid && used)) return 2'd0;
    for (int i = 0; i < MAXAGE; i++)
      if (mq[i].vld && mq[i].rd == x) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic logic exp_hazard();
    logic dep;
    dep = (exp_sel(id_rs_a, id_rs_a_used) == 2'd1) || (exp_sel(id_rs_b, id_rs_b_used) == 2'd1);
    return id_valid && !flush && dep && mq[0].ld;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 3; i++) mq.push_back('0);
  endtask

  // Sample outputs mid-cycle against the model.
  task automatic settle();
    @(negedge clk);
    chk("sel_a_model", fwd_sel_a, exp_sel(id_rs_a, id_rs_a_used));
    chk("sel_b_model", fwd_sel_b, exp_sel(id_rs_b, id_rs_b_used));
    chk("hazard_model", {1'b0, hazard_stall}, {1'b0, exp_hazard()});
  endtask

  // Clock edge: update the model the way the pipeline is described to move.
  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (!stall_ext) begin
      e.vld = id_valid && id_wr && !flush && !exp_hazard();
      e.rd  = id_rd;
      e.ld  = id_is_load;
      mq.push_front(e);
      void'(mq.pop_back());
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_rs_a = '0; id_rs_a_used = 1'b0;
    id_rs_b = '0; id_rs_b_used = 1'b0; id_wr = 1'b0; id_rd = '0;
    id_is_load = 1'b0; stall_ext = 1'b0; flush = 1'b0;
  endtask

  task automatic instr(input logic wr, input logic [4:0] rd, input logic ld,
                       input logic ua, input logic [4:0] ra,
                       input logic ub, input logic [4:0] rb);
    id_valid = 1'b1; id_wr = wr; id_rd = rd; id_is_load = ld;
    id_rs_a_used = ua; id_rs_a = ra; id_rs_b_used = ub; id_rs_b = rb;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    // Reset held two cycles with a live ID instruction; first cycle precedes any edge.
    idle(); rst = 1'b1;
    instr(1'b1, 5'd2, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    advance();
    settle();
    chk("rst_sel_a", fwd_sel_a, 2'd0);
    chk("rst_sel_b", fwd_sel_b, 2'd0);
    chk("rst_hazard", {1'b0, hazard_stall}, 2'd0);
    advance();
    idle();

    // ALU chain on r3 at distances 1, 2, 3.
    instr(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b1, 5'd4, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3); settle();
    chk("alu_d1_a", fwd_sel_a, 2'd1);
    chk("alu_d1_b", fwd_sel_b, 2'd1);
    advance();
    instr(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3); settle();
    chk("alu_d2_a", fwd_sel_a, 2'd2);
    advance();
    settle();
`ifdef FWD_WB_BYPASS_EN
    chk("alu_d3_a", fwd_sel_a, 2'd3);
`else
    chk("alu_d3_a", fwd_sel_a, 2'd0);
`endif
    advance();

    // Load-use on r5.
    do_reset();
    instr(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b1, 5'd6, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1); settle();
    chk("lu_hazard", {1'b0, hazard_stall}, 2'd1);
    chk("lu_sel_a_stalled", fwd_sel_a, 2'd1);
    advance();
    settle();
    chk("lu_sel_a_after", fwd_sel_a, 2'd2);
    chk("lu_sel_b_after", fwd_sel_b, 2'd0);
    chk("lu_hazard_after", {1'b0, hazard_stall}, 2'd0);
    advance();

    // Priority with r7 in all stages, then with EX holding another register.
    do_reset();
    repeat (3) begin
      instr(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    end
    instr(1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0); settle();
    chk("prio_all", fwd_sel_a, 2'd1);
    do_reset();
    instr(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    settle(); advance();
    instr(1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7); settle();
    chk("prio_no_ex_a", fwd_sel_a, 2'd2);
    chk("prio_no_ex_b", fwd_sel_b, 2'd2);
    advance();

    // External stall freezes tags.
    do_reset();
    instr(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b1, 5'd11, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0);
    stall_ext = 1'b1;
    repeat (3) begin
      settle();
      chk("stall_hold", fwd_sel_a, 2'd1);
      advance();
    end
    stall_ext = 1'b0;
    settle(); advance();
    settle();
    chk("stall_release", fwd_sel_a, 2'd2);
    advance();

    // Flush suppresses insertion.
    do_reset();
    instr(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1'b1; settle(); advance();
    flush = 1'b0;
    instr(1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0); settle();
    chk("flush_no_tag", fwd_sel_a, 2'd0);
    advance();

    // Reset with three live tags, even under stall and flush.
    instr(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); settle(); advance();
    instr(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd2);
    rst = 1'b1; stall_ext = 1'b1; flush = 1'b1;
    settle(); advance();
    rst = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    settle();
    chk("midrst_a", fwd_sel_a, 2'd0);
    chk("midrst_b", fwd_sel_b, 2'd0);
    advance();

    // Random traffic over a small register window to force frequent hits.
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(99) < 2);
      id_valid     = ($urandom_range(99) < 85);
      id_rs_a      = 5'($urandom_range(7));
      id_rs_b      = 5'($urandom_range(7));
      id_rs_a_used = 1'($urandom_range(1));
      id_rs_b_used = 1'($urandom_range(1));
      id_wr        = ($urandom_range(99) < 75);
      id_rd        = 5'($urandom_range(7));
      id_is_load   = ($urandom_range(99) < 30);
      stall_ext    = ($urandom_range(99) < 15);
      flush        = ($urandom_range(99) < 10);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
